// File: rtl/alu_mon_pkg.sv
// Shared types, parameter defaults and command classification for the ALU protocol monitor.
// Command encodings mirror the ALU's defines.svh so monitor and ALU decode identically.
package alu_mon_pkg;

    localparam int DWIDTH_DEF    = 8;
    localparam int CWIDTH_DEF    = 4;
    localparam int TIMEOUT_DEF   = 16;
    localparam int MUL_LAT_DEF   = 3;
    localparam int CNT_WIDTH_DEF = 16;

    // Arithmetic commands (mode = 1)
    localparam logic [31:0] CMD_ADD     = 32'd0;
    localparam logic [31:0] CMD_SUB     = 32'd1;
    localparam logic [31:0] CMD_ADD_CIN = 32'd2;
    localparam logic [31:0] CMD_SUB_CIN = 32'd3;
    localparam logic [31:0] CMD_INC_A   = 32'd4;
    localparam logic [31:0] CMD_DEC_A   = 32'd5;
    localparam logic [31:0] CMD_INC_B   = 32'd6;
    localparam logic [31:0] CMD_DEC_B   = 32'd7;
    localparam logic [31:0] CMD_CMP     = 32'd8;
    localparam logic [31:0] CMD_ADD_MUL = 32'd9;
    localparam logic [31:0] CMD_SH_MUL  = 32'd10;

    // Logical commands (mode = 0)
    localparam logic [31:0] CMD_AND     = 32'd0;
    localparam logic [31:0] CMD_NAND    = 32'd1;
    localparam logic [31:0] CMD_OR      = 32'd2;
    localparam logic [31:0] CMD_NOR     = 32'd3;
    localparam logic [31:0] CMD_XOR     = 32'd4;
    localparam logic [31:0] CMD_XNOR    = 32'd5;
    localparam logic [31:0] CMD_NOT_A   = 32'd6;
    localparam logic [31:0] CMD_NOT_B   = 32'd7;
    localparam logic [31:0] CMD_SHR1_A  = 32'd8;
    localparam logic [31:0] CMD_SHL1_A  = 32'd9;
    localparam logic [31:0] CMD_SHR1_B  = 32'd10;
    localparam logic [31:0] CMD_SHL1_B  = 32'd11;
    localparam logic [31:0] CMD_ROL_A_B = 32'd12;
    localparam logic [31:0] CMD_ROR_A_B = 32'd13;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_A,
        ST_WAIT_B,
        ST_MUL_WAIT
    } mon_state_e;

    function automatic logic is_two_op(input logic mode, input logic [31:0] cmd);
        if (mode) begin
            return cmd inside {CMD_ADD, CMD_SUB, CMD_ADD_CIN, CMD_SUB_CIN,
                               CMD_CMP, CMD_SH_MUL, CMD_ADD_MUL};
        end
        return cmd inside {CMD_AND, CMD_NAND, CMD_OR, CMD_NOR,
                           CMD_XOR, CMD_XNOR, CMD_ROL_A_B, CMD_ROR_A_B};
    endfunction

    function automatic logic is_mul(input logic mode, input logic [31:0] cmd);
        return mode && ((cmd == CMD_SH_MUL) || (cmd == CMD_ADD_MUL));
    endfunction

endpackage

// File: rtl/alu_mon_sat_cnt.sv
// Statistics counter that sticks at all-ones instead of wrapping.
module alu_mon_sat_cnt #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/alu_protocol_monitor.sv
// Watches the ALU's operand handshake, flags protocol violations and keeps
// saturating operation/error statistics. Every output comes straight from a flop.
module alu_protocol_monitor
    import alu_mon_pkg::*;
#(
    parameter int DWIDTH    = DWIDTH_DEF,
    parameter int CWIDTH    = CWIDTH_DEF,
    parameter int TIMEOUT   = TIMEOUT_DEF,
    parameter int MUL_LAT   = MUL_LAT_DEF,
    parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 ce_i,
    input  logic [DWIDTH-1:0]    opa_i,
    input  logic [DWIDTH-1:0]    opb_i,
    input  logic                 mode_i,
    input  logic                 cin_i,
    input  logic [1:0]           inp_valid_i,
    input  logic [CWIDTH-1:0]    cmd_i,
    input  logic [DWIDTH:0]      res_i,
    output logic                 pair_done_o,
    output logic                 mul_done_o,
    output logic                 err_timeout_o,
    output logic                 err_cmd_change_o,
    output logic                 err_hold_o,
    output logic                 busy_o,
    output logic [CNT_WIDTH-1:0] op_count_o,
    output logic [CNT_WIDTH-1:0] err_count_o
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int LW = $clog2(MUL_LAT + 1);
    localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT);
    localparam logic [LW-1:0] LAT_LAST  = LW'(MUL_LAT - 1);
    localparam logic [LW-1:0] LAT_PRE   = LW'((MUL_LAT >= 2) ? (MUL_LAT - 2) : 0);

    mon_state_e        state_q, state_d;
    logic [TW-1:0]     wait_q, wait_d, wait_nxt;
    logic [LW-1:0]     lat_q, lat_d;
    logic [CWIDTH-1:0] cmd_q, cmd_d;
    logic              mode_q, mode_d;
    logic              pair_done_q, pair_done_d;
    logic              mul_done_q, mul_done_d;
    logic              err_timeout_q, err_timeout_d;
    logic              err_cmd_change_q, err_cmd_change_d;
    logic              err_hold_q, err_hold_d;
    logic              busy_q;
    logic              ce_prev_q;
    logic [DWIDTH:0]   res_prev_q;
    logic              hist_valid_q;
    logic              cmd_same;
    logic              partner;
    logic              complete;
    logic              unused_data;

    // Operand data and carry are mirrored for completeness; the protocol checks ignore them.
    assign unused_data = ^{opa_i, opb_i, cin_i};

    always_comb begin
        state_d          = state_q;
        wait_d           = wait_q;
        lat_d            = lat_q;
        cmd_d            = cmd_q;
        mode_d           = mode_q;
        pair_done_d      = 1'b0;
        mul_done_d       = 1'b0;
        err_timeout_d    = 1'b0;
        err_cmd_change_d = 1'b0;
        complete         = 1'b0;
        wait_nxt         = wait_q + 1'b1;
        cmd_same         = (cmd_i == cmd_q) && (mode_i == mode_q);
        partner          = (state_q == ST_WAIT_A) ? inp_valid_i[0] : inp_valid_i[1];
        err_hold_d       = hist_valid_q && !ce_prev_q && (res_i != res_prev_q);

        case (state_q)
            ST_IDLE: begin
                if (ce_i && is_two_op(mode_i, 32'(cmd_i))) begin
                    cmd_d  = cmd_i;
                    mode_d = mode_i;
                    wait_d = '0;
                    case (inp_valid_i)
                        2'b11:   complete = 1'b1;
                        2'b01:   state_d  = ST_WAIT_B;
                        2'b10:   state_d  = ST_WAIT_A;
                        default: state_d  = ST_IDLE;
                    endcase
                end
            end
            ST_WAIT_A, ST_WAIT_B: begin
                // A command change outranks a partner arriving on the same cycle.
                if (ce_i) begin
                    if (!cmd_same) begin
                        err_cmd_change_d = 1'b1;
                        state_d          = ST_IDLE;
                    end else if (partner) begin
                        complete = 1'b1;
                    end else if (wait_nxt == WAIT_LAST) begin
                        err_timeout_d = 1'b1;
                        state_d       = ST_IDLE;
                    end else begin
                        wait_d = wait_nxt;
                    end
                end
            end
            ST_MUL_WAIT: begin
                if (ce_i && !cmd_same) begin
                    err_cmd_change_d = 1'b1;
                    state_d          = ST_IDLE;
                end else begin
                    lat_d = lat_q + 1'b1;
                    if ((MUL_LAT >= 2) && (lat_q == LAT_PRE)) begin
                        mul_done_d = 1'b1;
                    end
                    if (lat_q == LAT_LAST) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Busy spans the latency window; mul_done lands in its final cycle.
        if (complete) begin
            if (is_mul(mode_d, 32'(cmd_d))) begin
                state_d = ST_MUL_WAIT;
                lat_d   = '0;
                if (MUL_LAT == 1) begin
                    mul_done_d = 1'b1;
                end
            end else begin
                pair_done_d = 1'b1;
                state_d     = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q          <= ST_IDLE;
            wait_q           <= '0;
            lat_q            <= '0;
            cmd_q            <= '0;
            mode_q           <= 1'b0;
            pair_done_q      <= 1'b0;
            mul_done_q       <= 1'b0;
            err_timeout_q    <= 1'b0;
            err_cmd_change_q <= 1'b0;
            err_hold_q       <= 1'b0;
            busy_q           <= 1'b0;
            ce_prev_q        <= 1'b0;
            res_prev_q       <= '0;
            hist_valid_q     <= 1'b0;
        end else begin
            state_q          <= state_d;
            wait_q           <= wait_d;
            lat_q            <= lat_d;
            cmd_q            <= cmd_d;
            mode_q           <= mode_d;
            pair_done_q      <= pair_done_d;
            mul_done_q       <= mul_done_d;
            err_timeout_q    <= err_timeout_d;
            err_cmd_change_q <= err_cmd_change_d;
            err_hold_q       <= err_hold_d;
            busy_q           <= (state_d != ST_IDLE);
            ce_prev_q        <= ce_i;
            res_prev_q       <= res_i;
            hist_valid_q     <= 1'b1;
        end
    end

    alu_mon_sat_cnt #(.WIDTH(CNT_WIDTH)) u_op_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (pair_done_d | mul_done_d),
        .count_o (op_count_o)
    );

    alu_mon_sat_cnt #(.WIDTH(CNT_WIDTH)) u_err_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (err_timeout_d | err_cmd_change_d | err_hold_d),
        .count_o (err_count_o)
    );

    assign pair_done_o      = pair_done_q;
    assign mul_done_o       = mul_done_q;
    assign err_timeout_o    = err_timeout_q;
    assign err_cmd_change_o = err_cmd_change_q;
    assign err_hold_o       = err_hold_q;
    assign busy_o           = busy_q;

endmodule

// File: tb/tb_alu_protocol_monitor.sv
// Directed bench for the ALU protocol monitor; three instances share stimulus
// (default, MUL_LAT=5, CNT_WIDTH=2).
module tb_alu_protocol_monitor;
    import alu_mon_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ce = 1'b0;
    logic       mode = 1'b0;
    logic       cin = 1'b0;
    logic [7:0] opa = 8'h12;
    logic [7:0] opb = 8'h34;
    logic [1:0] iv = 2'b00;
    logic [3:0] cmd = 4'd0;
    logic [8:0] res = 9'h000;

    logic        pair_done, mul_done, err_to, err_chg, err_hold, busy;
    logic [15:0] op_count, err_count;

    logic        l5_mul_done, l5_busy;
    logic [15:0] l5_op_count;
    logic        l5_unused_pair, l5_unused_to, l5_unused_chg, l5_unused_hold;
    logic [15:0] l5_unused_err;

    logic [1:0]  c2_op_count;
    logic        c2_unused_pair, c2_unused_mul, c2_unused_to, c2_unused_chg;
    logic        c2_unused_hold, c2_unused_busy;
    logic [1:0]  c2_unused_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_protocol_monitor dut (
        .clk_i(clk), .rst_i(rst), .ce_i(ce), .opa_i(opa), .opb_i(opb),
        .mode_i(mode), .cin_i(cin), .inp_valid_i(iv), .cmd_i(cmd), .res_i(res),
        .pair_done_o(pair_done), .mul_done_o(mul_done), .err_timeout_o(err_to),
        .err_cmd_change_o(err_chg), .err_hold_o(err_hold), .busy_o(busy),
        .op_count_o(op_count), .err_count_o(err_count)
    );

    alu_protocol_monitor #(.MUL_LAT(5)) dut_l5 (
        .clk_i(clk), .rst_i(rst), .ce_i(ce), .opa_i(opa), .opb_i(opb),
        .mode_i(mode), .cin_i(cin), .inp_valid_i(iv), .cmd_i(cmd), .res_i(res),
        .pair_done_o(l5_unused_pair), .mul_done_o(l5_mul_done), .err_timeout_o(l5_unused_to),
        .err_cmd_change_o(l5_unused_chg), .err_hold_o(l5_unused_hold), .busy_o(l5_busy),
        .op_count_o(l5_op_count), .err_count_o(l5_unused_err)
    );

    alu_protocol_monitor #(.CNT_WIDTH(2)) dut_c2 (
        .clk_i(clk), .rst_i(rst), .ce_i(ce), .opa_i(opa), .opb_i(opb),
        .mode_i(mode), .cin_i(cin), .inp_valid_i(iv), .cmd_i(cmd), .res_i(res),
        .pair_done_o(c2_unused_pair), .mul_done_o(c2_unused_mul), .err_timeout_o(c2_unused_to),
        .err_cmd_change_o(c2_unused_chg), .err_hold_o(c2_unused_hold), .busy_o(c2_unused_busy),
        .op_count_o(c2_op_count), .err_count_o(c2_unused_err)
    );

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic c, input logic m, input logic [1:0] v, input logic [31:0] k);
        ce   = c;
        mode = m;
        iv   = v;
        cmd  = 4'(k);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 2'b00, CMD_AND);
        res = 9'h000;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({pair_done, mul_done, err_to, err_chg, err_hold, busy} !== 6'b0) begin
            bad++;
            $display("[TB] FAIL reset_flags: got %b want 000000",
                     {pair_done, mul_done, err_to, err_chg, err_hold, busy});
        end
        total++;
        if (op_count !== 16'd0) begin bad++; $display("[TB] FAIL reset_op_count: got %0d want 0", op_count); end
        total++;
        if (err_count !== 16'd0) begin bad++; $display("[TB] FAIL reset_err_count: got %0d want 0", err_count); end
    endtask

    task automatic test_single_add();
        do_reset();
        drive(1'b1, 1'b1, 2'b11, CMD_ADD);
        tick();
        total++;
        if (pair_done !== 1'b1) begin bad++; $display("[TB] FAIL add_pair_done: got %b want 1", pair_done); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("[TB] FAIL add_busy: got %b want 0", busy); end
        total++;
        if (op_count !== 16'd1) begin bad++; $display("[TB] FAIL add_op_count: got %0d want 1", op_count); end
        drive(1'b0, 1'b1, 2'b00, CMD_ADD);
        tick();
        total++;
        if ({pair_done, busy} !== 2'b00) begin bad++; $display("[TB] FAIL add_after: got %b want 00", {pair_done, busy}); end
    endtask

    task automatic test_ignored_cmd();
        do_reset();
        drive(1'b1, 1'b1, 2'b11, CMD_INC_A);
        tick();
        total++;
        if ({pair_done, busy, op_count} !== 18'd0) begin
            bad++;
            $display("[TB] FAIL ignored_inc_a: got pair=%b busy=%b ops=%0d want 0/0/0", pair_done, busy, op_count);
        end
    endtask

    task automatic test_pair_timeout();
        do_reset();
        drive(1'b1, 1'b0, 2'b01, CMD_AND);
        tick();
        total++;
        if (busy !== 1'b1) begin bad++; $display("[TB] FAIL and_wait_busy: got %b want 1", busy); end
        drive(1'b1, 1'b0, 2'b00, CMD_AND);
        for (int i = 1; i <= 15; i++) tick();
        drive(1'b1, 1'b0, 2'b10, CMD_AND);
        tick();
        total++;
        if ({pair_done, err_to} !== 2'b10) begin
            bad++;
            $display("[TB] FAIL and_pair_at_16: got pair=%b to=%b want 1/0", pair_done, err_to);
        end
        drive(1'b1, 1'b0, 2'b01, CMD_AND);
        tick();
        drive(1'b1, 1'b0, 2'b00, CMD_AND);
        for (int i = 1; i <= 15; i++) tick();
        total++;
        if ({err_to, busy} !== 2'b01) begin
            bad++;
            $display("[TB] FAIL and_before_timeout: got to=%b busy=%b want 0/1", err_to, busy);
        end
        tick();
        total++;
        if ({err_to, busy} !== 2'b10) begin
            bad++;
            $display("[TB] FAIL and_timeout: got to=%b busy=%b want 1/0", err_to, busy);
        end
        total++;
        if (err_count !== 16'd1) begin bad++; $display("[TB] FAIL timeout_err_count: got %0d want 1", err_count); end
        tick();
        total++;
        if (err_to !== 1'b0) begin bad++; $display("[TB] FAIL timeout_pulse_width: got %b want 0", err_to); end
    endtask

    task automatic test_mul_latency();
        logic exp3;
        logic exp5;
        do_reset();
        drive(1'b1, 1'b1, 2'b11, CMD_SH_MUL);
        tick();
        for (int k = 1; k <= 6; k++) begin
            exp3 = (k == 3);
            exp5 = (k == 5);
            total++;
            if ({mul_done, busy, pair_done} !== {exp3, (k <= 3), 1'b0}) begin
                bad++;
                $display("[TB] FAIL mul3 k=%0d: got done/busy/pair=%b%b%b want %b%b0",
                         k, mul_done, busy, pair_done, exp3, (k <= 3));
            end
            total++;
            if ({l5_mul_done, l5_busy} !== {exp5, (k <= 5)}) begin
                bad++;
                $display("[TB] FAIL mul5 k=%0d: got done/busy=%b%b want %b%b",
                         k, l5_mul_done, l5_busy, exp5, (k <= 5));
            end
            if (k <= 1) drive(1'b1, 1'b1, 2'b11, CMD_SH_MUL);
            else        drive(1'b0, 1'b1, 2'b00, CMD_SH_MUL);
            tick();
        end
        total++;
        if ({op_count, l5_op_count} !== {16'd1, 16'd1}) begin
            bad++;
            $display("[TB] FAIL mul_op_count: got %0d/%0d want 1/1", op_count, l5_op_count);
        end
    endtask

    task automatic test_cmd_change();
        do_reset();
        drive(1'b1, 1'b1, 2'b01, CMD_SUB);
        tick();
        drive(1'b1, 1'b1, 2'b10, CMD_ADD);
        tick();
        total++;
        if ({err_chg, pair_done, busy} !== 3'b100) begin
            bad++;
            $display("[TB] FAIL cmd_change: got chg/pair/busy=%b%b%b want 100", err_chg, pair_done, busy);
        end
        drive(1'b1, 1'b1, 2'b00, CMD_ADD);
        tick();
        total++;
        if ({err_chg, busy, err_count} !== {2'b00, 16'd1}) begin
            bad++;
            $display("[TB] FAIL cmd_change_after: got chg=%b busy=%b errs=%0d want 0/0/1", err_chg, busy, err_count);
        end
    endtask

    task automatic test_hold();
        do_reset();
        drive(1'b1, 1'b1, 2'b00, CMD_INC_A);
        res = 9'h005;
        tick();
        drive(1'b0, 1'b1, 2'b00, CMD_INC_A);
        tick();
        total++;
        if (err_hold !== 1'b0) begin bad++; $display("[TB] FAIL hold_early: got %b want 0", err_hold); end
        res = 9'h006;
        tick();
        total++;
        if (err_hold !== 1'b1) begin bad++; $display("[TB] FAIL hold_pulse: got %b want 1", err_hold); end
        drive(1'b1, 1'b1, 2'b00, CMD_INC_A);
        tick();
        total++;
        if ({err_hold, err_count} !== {1'b0, 16'd1}) begin
            bad++;
            $display("[TB] FAIL hold_single: got hold=%b errs=%0d want 0/1", err_hold, err_count);
        end
        drive(1'b1, 1'b0, 2'b10, CMD_OR);
        tick();
        drive(1'b0, 1'b0, 2'b00, CMD_OR);
        for (int i = 0; i < 20; i++) begin
            tick();
            total++;
            if ({err_to, busy} !== 2'b01) begin
                bad++;
                $display("[TB] FAIL ce_low_wait i=%0d: got to=%b busy=%b want 0/1", i, err_to, busy);
            end
        end
        drive(1'b1, 1'b0, 2'b01, CMD_OR);
        tick();
        total++;
        if ({pair_done, err_to} !== 2'b10) begin
            bad++;
            $display("[TB] FAIL ce_low_pair: got pair=%b to=%b want 1/0", pair_done, err_to);
        end
    endtask

    task automatic test_reset_hold();
        drive(1'b0, 1'b1, 2'b00, CMD_INC_A);
        res = 9'h011;
        tick();
        rst = 1'b1;
        res = 9'h022;
        tick();
        rst = 1'b0;
        res = 9'h033;
        tick();
        total++;
        if (err_hold !== 1'b0) begin bad++; $display("[TB] FAIL hold_first_after_reset: got %b want 0", err_hold); end
        res = 9'h044;
        tick();
        total++;
        if (err_hold !== 1'b1) begin bad++; $display("[TB] FAIL hold_second_after_reset: got %b want 1", err_hold); end
    endtask

    task automatic test_reset_mul();
        do_reset();
        drive(1'b1, 1'b1, 2'b11, CMD_ADD_MUL);
        tick();
        drive(1'b0, 1'b1, 2'b00, CMD_ADD_MUL);
        tick();
        total++;
        if ({busy, l5_busy} !== 2'b11) begin bad++; $display("[TB] FAIL mul_busy_before_rst: got %b want 11", {busy, l5_busy}); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            total++;
            if ({pair_done, mul_done, err_to, err_chg, err_hold, busy, l5_mul_done, l5_busy} !== 8'b0
                || op_count !== 16'd0 || err_count !== 16'd0 || l5_op_count !== 16'd0) begin
                bad++;
                $display("[TB] FAIL rst_in_mul k=%0d: got flags=%b ops=%0d errs=%0d l5ops=%0d want all 0", k,
                         {pair_done, mul_done, err_to, err_chg, err_hold, busy, l5_mul_done, l5_busy},
                         op_count, err_count, l5_op_count);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 2'b11, CMD_ADD);
            tick();
            total++;
            if (pair_done !== 1'b1) begin bad++; $display("[TB] FAIL b2b_pair i=%0d: got %b want 1", i, pair_done); end
        end
        drive(1'b0, 1'b1, 2'b00, CMD_ADD);
        tick();
        total++;
        if (c2_op_count !== 2'b11) begin bad++; $display("[TB] FAIL sat_op_count: got %0d want 3", c2_op_count); end
        total++;
        if (op_count !== 16'd5) begin bad++; $display("[TB] FAIL b2b_op_count: got %0d want 5", op_count); end
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_ignored_cmd();
        test_pair_timeout();
        test_mul_latency();
        test_cmd_change();
        test_hold();
        test_reset_hold();
        test_reset_mul();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
